// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the regfile write port between the ALU and MUL/DIV writeback paths,
// tracking MUL/DIV destination ownership to stall hazardous issues.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            md_ready,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     busy_vec
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic            run_q;
    logic [31:0]     busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic md_win, md_acc, alu_acc, long_issue;

    // run_q keeps both producers unaccepted until the first edge after reset release.
    always_comb begin
        md_win      = md_valid && (!alu_valid || (starve_q == STARVE_MAX));
        md_ready    = run_q && md_win;
        alu_ready   = run_q && alu_valid && !md_win;
        md_acc      = md_valid && md_ready;
        alu_acc     = alu_valid && alu_ready;
        issue_stall = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] ||
                      busy_q[issue_rd] || (issue_long && (cnt_q == CNT_MAX)));
        long_issue  = issue_valid && issue_long && !issue_stall;
    end

    always_comb begin
        starve_d = starve_q;
        if (!md_valid || md_acc) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Clear is applied before set so a same-edge set of the same bit wins.
    always_comb begin
        busy_d = busy_q;
        if (md_acc) begin
            busy_d[md_rd] = 1'b0;
        end
        if (long_issue) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (long_issue && !md_acc) begin
            cnt_d = cnt_q + CW'(1);
        end else if (md_acc && !long_issue && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (md_acc) begin
            if (md_rd != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_rd_d    = md_rd;
                rf_wdata_d = md_data;
            end
        end else if (alu_acc) begin
            if (alu_rd != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_rd_d    = alu_rd;
                rf_wdata_d = alu_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            busy_q     <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            run_q      <= 1'b1;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign busy_vec = busy_q;

    a_md_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        md_acc |-> (cnt_q != '0));
    a_md_rd_owned: assert property (@(posedge clk) disable iff (!rst_n)
        (md_acc && (md_rd != 5'd0)) |-> busy_q[md_rd]);

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 register file between two producers:
  - the single-cycle ALU writeback path;
  - the multi-cycle MUL/DIV unit.
- Keeps a busy-bit scoreboard of destination registers owned by in-flight MUL/DIV ops.
- Raises a stall to the issue stage on RAW/WAW hazards against those registers.
- Sits between the execute stage and the register file. Drives the regfile's write enable, rd and write_data.

Parameters:
- XLEN, 32, data width of write data.
- MAX_OUTSTANDING, 2, max in-flight MUL/DIV ops (1..31).
- STARVE_LIMIT, 4, consecutive cycles MUL/DIV may lose arbitration before it is forced to win (>=1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- issue_valid  input  1  instruction presented at issue.
- issue_long  input  1  presented instruction is MUL/DIV.
- issue_rs1  input  5  source 1 of presented instruction.
- issue_rs2  input  5  source 2 of presented instruction.
- issue_rd  input  5  destination of presented instruction.
- issue_stall  output  1  combinational; issue must hold the instruction.
- alu_valid  input  1  ALU result available.
- alu_rd  input  5  ALU destination.
- alu_data  input  XLEN  ALU result.
- alu_ready  output  1  combinational; ALU result accepted this cycle.
- md_valid  input  1  MUL/DIV result available.
- md_rd  input  5  MUL/DIV destination.
- md_data  input  XLEN  MUL/DIV result.
- md_ready  output  1  combinational; MUL/DIV result accepted this cycle.
- rf_we  output  1  registered regfile write enable.
- rf_rd  output  5  registered regfile destination.
- rf_wdata  output  XLEN  registered regfile write data.
- busy_vec  output  32  scoreboard; bit i set = xi owned by an in-flight MUL/DIV.

Behaviour:

Reset (asynchronous on rst_n low):
- rf_we=0, rf_rd=0, rf_wdata=0, busy_vec=0.
- Outstanding count=0, starvation counter=0.
- No write may reach the regfile while rst_n is low or on the first edge after release.
- Reset mid-operation discards all scoreboard state; producers are also reset.

Handshake:
- A result transfers on valid&&ready in the same cycle.
- Producers hold valid, rd and data stable until ready.

Arbitration, each cycle:
- Only alu_valid: alu_ready=1.
- Only md_valid: md_ready=1.
- Both valid: ALU wins unless the starvation counter equals STARVE_LIMIT, in which case MUL/DIV wins.
- Exactly one ready is high when either valid is high.

Starvation counter:
- Increments when md_valid && !md_ready.
- Clears to 0 when MUL/DIV is accepted or md_valid=0.
- Saturates at STARVE_LIMIT.

Writeback, one cycle after acceptance:
- rf_we=1; rf_rd and rf_wdata take the winner's rd and data.
- If no acceptance, rf_we=0; rf_rd and rf_wdata hold their previous values.
- rd==0 results: accepted normally (ready asserted), but rf_we stays 0 and the result consumes the slot.

Scoreboard:
- Bit 0 is always 0.
- Set busy[issue_rd] on an edge where issue_valid && issue_long && !issue_stall && issue_rd!=0.
- Clear busy[md_rd] on an edge where md_valid && md_ready.
- Set and clear of the same bit on one edge: set wins.

Outstanding count:
- +1 on a long issue.
- -1 on MUL/DIV acceptance.
- Both on one edge: unchanged.
- Counts rd==0 ops too.

issue_stall is high when issue_valid and any of:
- busy[issue_rs1];
- busy[issue_rs2];
- busy[issue_rd];
- issue_long && count==MAX_OUTSTANDING.

A clear on the current edge does not release the stall until the next cycle, so there is no bypass through the scoreboard.

Assertions:
- MUL/DIV acceptance when count==0 is an error.
- MUL/DIV acceptance with busy[md_rd]==0 is an error, except md_rd==0.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with all valids high -> rf_we=0, busy_vec=0, no write until after release.
- ALU-only stream: alu_valid with rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- Long issue hazard: issue MUL rd=7; next instruction has rs1=7 -> busy_vec[7]=1 and issue_stall=1. md_valid rd=7 accepted -> stall drops one cycle after acceptance; rf_rd=7 written.
- Starvation with STARVE_LIMIT=4: alu_valid and md_valid both held high -> ALU wins 4 cycles, md_ready=1 on the 5th with alu_ready=0. ALU wins the following cycle.
- Outstanding limit with MAX_OUTSTANDING=2: issue two MUL ops to rd=3 and rd=4, then a third MUL to rd=9 -> third stalls until one MUL result is accepted.
- x0 and same-edge cases:
  - MUL to rd=0 -> busy_vec[0] stays 0; its result is accepted with rf_we=0.
  - Accepting md_rd=6 on the same edge as issuing a long op to rd=6 -> busy_vec[6]=1 afterwards.
